// File: rtl/apb_pkg.sv
// Shared types and default constants for the APB manager slice.
// Holds the bus-state enum, the default decode window and the default
// ACCESS wait limit, plus a helper that sizes the optional timeout counter.
package apb_pkg;

    typedef enum logic [1:0] {
        APB_IDLE   = 2'd0,
        APB_SETUP  = 2'd1,
        APB_ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] APB_DEFAULT_BASE_ADDR      = 32'h1000_0000;
    localparam int          APB_DEFAULT_SLOT_BITS      = 12;
    localparam int          APB_DEFAULT_TIMEOUT_CYCLES = 255;

    // Width of the ACCESS timeout counter: never narrower than 8 bits and
    // always wide enough to hold the configured limit.
    function automatic int timeout_cnt_width(input int cycles);
        int w;
        w = $clog2(cycles + 1);
        return (w < 8) ? 8 : w;
    endfunction

endpackage

// File: rtl/apb_slot_decode.sv
// Combinational slot decoder for the APB manager.
// Maps the latched bus address onto one subordinate slot inside a window of
// NUM_SUB equally sized slots starting at BASE_ADDR. Addresses outside the
// window give no select and hit=0. Nothing is selected while en is low.
module apb_slot_decode
    import apb_pkg::*;
#(
    parameter int          NUM_SUB   = 4,
    parameter logic [31:0] BASE_ADDR = APB_DEFAULT_BASE_ADDR,
    parameter int          SLOT_BITS = APB_DEFAULT_SLOT_BITS
) (
    input  logic [31:0]                PADDR,
    input  logic                       en,
    output logic [NUM_SUB-1:0]         sel,
    output logic [$clog2(NUM_SUB)-1:0] idx,
    output logic                       hit
);

    localparam int          IDX_W  = $clog2(NUM_SUB);
    // Window bounds are kept 33 bits wide so a window that ends exactly at
    // the top of the 4 GiB space does not wrap.
    localparam logic [32:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [32:0] WIN_HI = WIN_LO + (33'(NUM_SUB) << SLOT_BITS);

    logic [32:0] addr_ext;

    // Range check, slot extraction and one-hot select generation.
    always_comb begin
        addr_ext = {1'b0, PADDR};
        idx      = PADDR[SLOT_BITS +: IDX_W];
        hit      = en && (addr_ext >= WIN_LO) && (addr_ext < WIN_HI)
                   && (int'(idx) < NUM_SUB);
        for (int k = 0; k < NUM_SUB; k++) begin
            sel[k] = hit && (int'(idx) == k);
        end
    end

endmodule

// File: rtl/apb_manager_nch.sv
// APB manager driving NUM_SUB subordinate slots from a simple request port.
// A request is taken in IDLE or on the completing ACCESS cycle, walked
// through SETUP and ACCESS, and answered with a one-cycle ready pulse.
// Addresses outside the decode window finish at once with error=1.
// Optional feature: define APB_MANAGER_TIMEOUT_EN to abort an ACCESS phase
// that has waited TIMEOUT_CYCLES cycles without PREADY.
module apb_manager_nch
    import apb_pkg::*;
#(
    parameter int          NUM_SUB        = 4,
    parameter int          DATA_W         = 32,
    parameter logic [31:0] BASE_ADDR      = APB_DEFAULT_BASE_ADDR,
    parameter int          SLOT_BITS      = APB_DEFAULT_SLOT_BITS,
    parameter int          TIMEOUT_CYCLES = APB_DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      PCLK,
    input  logic                      PRESET,
    output logic [31:0]               PADDR,
    output logic                      PWRITE,
    output logic [DATA_W-1:0]         PWDATA,
    output logic [DATA_W/8-1:0]       PSTRB,
    output logic [NUM_SUB-1:0]        PSEL,
    output logic                      PENABLE,
    input  logic [NUM_SUB*DATA_W-1:0] PRDATA,
    input  logic [NUM_SUB-1:0]        PREADY,
    input  logic [NUM_SUB-1:0]        PSLVERR,
    input  logic                      transfer,
    input  logic                      write,
    input  logic [31:0]               addr,
    input  logic [DATA_W-1:0]         wdata,
    input  logic [DATA_W/8-1:0]       strb,
    output logic [DATA_W-1:0]         rdata,
    output logic                      ready,
    output logic                      error,
    output logic                      busy
);

    localparam int IDX_W = $clog2(NUM_SUB);

    // Reject configurations the decoder and strobe logic cannot represent.
    if (NUM_SUB < 2 || NUM_SUB > 16 || DATA_W < 8 || (DATA_W % 8) != 0
        || SLOT_BITS < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("apb_manager_nch: illegal parameter combination");
    end

    apb_state_e          state;
    apb_state_e          state_nxt;
    logic [NUM_SUB-1:0]  dec_sel;
    logic [IDX_W-1:0]    dec_idx;
    logic                dec_hit;
    logic [DATA_W-1:0]   slot_rdata;
    logic                slot_ready;
    logic                slot_err;
    logic                timeout_hit;
    logic                complete;
    logic                abort;
    logic                accept;

    apb_slot_decode #(
        .NUM_SUB   (NUM_SUB),
        .BASE_ADDR (BASE_ADDR),
        .SLOT_BITS (SLOT_BITS)
    ) u_decode (
        .PADDR (PADDR),
        .en    (state != APB_IDLE),
        .sel   (dec_sel),
        .idx   (dec_idx),
        .hit   (dec_hit)
    );

    // Pick read data, ready and error of the addressed slot; an unmapped
    // address leaves all three at zero.
    always_comb begin
        slot_rdata = '0;
        slot_ready = 1'b0;
        slot_err   = 1'b0;
        for (int k = 0; k < NUM_SUB; k++) begin
            if (dec_hit && (int'(dec_idx) == k)) begin
                slot_rdata = PRDATA[k*DATA_W +: DATA_W];
                slot_ready = PREADY[k];
                slot_err   = PSLVERR[k];
            end
        end
    end

`ifdef APB_MANAGER_TIMEOUT_EN
    localparam int TO_W = timeout_cnt_width(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt;

    // Count ACCESS cycles of the current transfer; cleared whenever the
    // transfer completes or the bus is not in ACCESS.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            to_cnt <= '0;
        end else if (state == APB_ACCESS && !complete) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    assign timeout_hit = (state == APB_ACCESS)
                         && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    // Completion, abort and request-acceptance conditions plus the
    // next-state decision and the bus-phase outputs.
    always_comb begin
        complete  = (state == APB_ACCESS)
                    && (!dec_hit || slot_ready || timeout_hit);
        abort     = !dec_hit || (timeout_hit && !slot_ready);
        accept    = transfer && ((state == APB_IDLE) || complete);
        state_nxt = state;
        case (state)
            APB_IDLE:   if (transfer) state_nxt = APB_SETUP;
            APB_SETUP:  state_nxt = APB_ACCESS;
            APB_ACCESS: if (complete) state_nxt = transfer ? APB_SETUP : APB_IDLE;
            default:    state_nxt = APB_IDLE;
        endcase
        PSEL    = dec_sel;
        PENABLE = (state == APB_ACCESS);
        busy    = (state != APB_IDLE);
    end

    // Bus state register.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state <= APB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture a new request; strobes are meaningless on reads so they are
    // driven low for the whole read transfer.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            PADDR  <= '0;
            PWRITE <= 1'b0;
            PWDATA <= '0;
            PSTRB  <= '0;
        end else if (accept) begin
            PADDR  <= addr;
            PWRITE <= write;
            PWDATA <= wdata;
            PSTRB  <= write ? strb : '0;
        end
    end

    // Response side: one-cycle ready pulse with error, read data captured
    // on read completion and cleared for unmapped or aborted transfers.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            ready <= 1'b0;
            error <= 1'b0;
            rdata <= '0;
        end else begin
            ready <= complete;
            error <= complete && (abort || slot_err);
            if (complete && abort) begin
                rdata <= '0;
            end else if (complete && !PWRITE) begin
                rdata <= slot_rdata;
            end
        end
    end

endmodule

// File: tb/tb_apb_manager_nch.sv
// Self-checking bench for apb_manager_nch.
// Requests are run through a fixed-timing driver that also plays the
// subordinates; expected bus and response values come from a transaction
// level model (address window arithmetic and a remembered read result).
module tb_apb_manager_nch;

    localparam int          NUM_SUB    = 4;
    localparam int          DATA_W     = 32;
    localparam int          TB_TIMEOUT = 4;
    localparam logic [31:0] BASE       = 32'h1000_0000;
    localparam longint      SLOT_BYTES = 4096;

    logic                      PCLK = 1'b0;
    logic                      PRESET = 1'b1;
    logic [31:0]               PADDR;
    logic                      PWRITE;
    logic [DATA_W-1:0]         PWDATA;
    logic [DATA_W/8-1:0]       PSTRB;
    logic [NUM_SUB-1:0]        PSEL;
    logic                      PENABLE;
    logic [NUM_SUB*DATA_W-1:0] PRDATA = '0;
    logic [NUM_SUB-1:0]        PREADY = '0;
    logic [NUM_SUB-1:0]        PSLVERR = '0;
    logic                      transfer = 1'b0;
    logic                      write = 1'b0;
    logic [31:0]               addr = '0;
    logic [DATA_W-1:0]         wdata = '0;
    logic [DATA_W/8-1:0]       strb = '0;
    logic [DATA_W-1:0]         rdata;
    logic                      ready;
    logic                      error;
    logic                      busy;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  st;
        int          stall;
        logic        slverr;
        logic [31:0] rdval;
        logic        stuck;
    } req_t;

    req_t        reqQ[$];
    logic [31:0] modelRdata = '0;
    int          vecCount = 0;
    int          missCount = 0;
    int          cyc = 0;
    int          lastReadyCyc = 0;

    apb_manager_nch #(
        .NUM_SUB        (NUM_SUB),
        .DATA_W         (DATA_W),
        .BASE_ADDR      (BASE),
        .SLOT_BITS      (12),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .PCLK     (PCLK),
        .PRESET   (PRESET),
        .PADDR    (PADDR),
        .PWRITE   (PWRITE),
        .PWDATA   (PWDATA),
        .PSTRB    (PSTRB),
        .PSEL     (PSEL),
        .PENABLE  (PENABLE),
        .PRDATA   (PRDATA),
        .PREADY   (PREADY),
        .PSLVERR  (PSLVERR),
        .transfer (transfer),
        .write    (write),
        .addr     (addr),
        .wdata    (wdata),
        .strb     (strb),
        .rdata    (rdata),
        .ready    (ready),
        .error    (error),
        .busy     (busy)
    );

    // 100 MHz bus clock.
    always #5 PCLK = ~PCLK;

    // Free-running edge counter used to measure spacing of ready pulses.
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic bit isMapped(input logic [31:0] a);
        longint la;
        longint lb;
        la = longint'({32'h0, a});
        lb = longint'({32'h0, BASE});
        return (la >= lb) && (la < lb + NUM_SUB * SLOT_BYTES);
    endfunction

    function automatic int slotOf(input logic [31:0] a);
        return int'((a - BASE) / 32'h1000);
    endfunction

    function automatic req_t mkReq(input logic wr, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [3:0] st,
                                   input int stall, input logic slverr,
                                   input logic [31:0] rdval);
        req_t r;
        r.wr = wr; r.a = a; r.wd = wd; r.st = st; r.stall = stall;
        r.slverr = slverr; r.rdval = rdval; r.stuck = 1'b0;
        return r;
    endfunction

    function automatic req_t randReq();
        req_t r;
        int   pick;
        r = mkReq(1'($urandom_range(0, 1)), 32'h0, $urandom, 4'($urandom_range(0, 15)),
                  int'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0), $urandom);
        pick = int'($urandom_range(0, 9));
        if (pick < 8) begin
            r.a = BASE + 32'($urandom_range(0, NUM_SUB - 1)) * 32'h1000 + ($urandom & 32'hFFC);
        end else if (pick == 8) begin
            r.a = BASE - 32'($urandom_range(1, 64)) * 32'd4;
        end else begin
            r.a = BASE + 32'h4000 + ($urandom & 32'h0FFF_FFFC);
        end
        return r;
    endfunction

    task automatic driveReq(input req_t r);
        transfer = 1'b1;
        write    = r.wr;
        addr     = r.a;
        wdata    = r.wd;
        strb     = r.st;
    endtask

    // Noise on the request port while a transfer is in flight; none of it
    // may be taken or disturb the latched bus fields.
    task automatic driveJunk();
        transfer = 1'($urandom_range(0, 1));
        write    = 1'($urandom_range(0, 1));
        addr     = $urandom;
        wdata    = $urandom;
        strb     = 4'($urandom_range(0, 15));
    endtask

    task automatic randSubs();
        for (int k = 0; k < NUM_SUB; k++) PRDATA[k*DATA_W +: DATA_W] = $urandom;
        PSLVERR = 4'($urandom_range(0, 15));
        PREADY  = 4'($urandom_range(0, 15));
    endtask

    // Runs every request in reqQ; chained=1 keeps transfer high so each
    // request is taken on the completing cycle of the one before it.
    task automatic applyStimulus(input bit chained);
        req_t        r;
        bit          mapped;
        bit          last;
        int          slot;
        int          lowCycles;
        int          n;
        logic [3:0]  expSel;
        logic        expErr;
        logic [31:0] expRd;
        n = reqQ.size();
        driveReq(reqQ[0]);
        @(posedge PCLK); #1;
        for (int i = 0; i < n; i++) begin
            r         = reqQ[i];
            last      = !(chained && (i + 1 < n));
            mapped    = isMapped(r.a);
            slot      = mapped ? slotOf(r.a) : 0;
            expSel    = mapped ? 4'(1 << slot) : 4'b0000;
            lowCycles = !mapped ? 0 : (r.stuck ? TB_TIMEOUT - 1 : r.stall);
            checkOutput("setup_busy", busy, 1);
            checkOutput("setup_psel", PSEL, expSel);
            checkOutput("setup_penable", PENABLE, 0);
            checkOutput("setup_paddr", PADDR, r.a);
            checkOutput("setup_pwrite", PWRITE, r.wr);
            checkOutput("setup_pwdata", PWDATA, r.wd);
            checkOutput("setup_pstrb", PSTRB, r.wr ? r.st : 4'h0);
            randSubs();
            if (mapped) begin
                PRDATA[slot*DATA_W +: DATA_W] = r.rdval;
                PSLVERR[slot] = r.slverr;
            end
            driveJunk();
            @(posedge PCLK); #1;
            for (int s = 0; s <= lowCycles; s++) begin
                if (s > 0) begin
                    @(posedge PCLK); #1;
                end
                checkOutput("access_penable", PENABLE, 1);
                checkOutput("access_psel", PSEL, expSel);
                checkOutput("access_paddr", PADDR, r.a);
                checkOutput("access_pwdata", PWDATA, r.wd);
                checkOutput("access_ready", ready, 0);
                if (mapped) PREADY[slot] = (s == lowCycles) && !r.stuck;
                if (s == lowCycles) begin
                    if (last) transfer = 1'b0;
                    else driveReq(reqQ[i+1]);
                end else begin
                    driveJunk();
                end
            end
            @(posedge PCLK); #1;
            expErr = (!mapped || r.stuck) ? 1'b1 : r.slverr;
            expRd  = (!mapped || r.stuck) ? 32'h0 : (r.wr ? modelRdata : r.rdval);
            modelRdata = expRd;
            checkOutput("done_ready", ready, 1);
            checkOutput("done_error", error, expErr);
            checkOutput("done_rdata", rdata, expRd);
            if (chained && i > 0) checkOutput("b2b_gap", cyc - lastReadyCyc, 2 + lowCycles);
            lastReadyCyc = cyc;
            if (last) begin
                checkOutput("done_idle_busy", busy, 0);
                @(posedge PCLK); #1;
                checkOutput("pulse_end_ready", ready, 0);
                checkOutput("pulse_end_error", error, 0);
                checkOutput("idle_psel", PSEL, 0);
                checkOutput("idle_penable", PENABLE, 0);
                if (i + 1 < n) begin
                    driveReq(reqQ[i+1]);
                    @(posedge PCLK); #1;
                end
            end
        end
        reqQ.delete();
    endtask

    // Reset in the middle of a stalled ACCESS phase.
    task automatic applyResetMidAccess();
        driveReq(mkReq(1'b0, 32'h1000_1008, 32'h0, 4'h0, 0, 1'b0, 32'h0));
        @(posedge PCLK); #1;
        transfer = 1'b0;
        PREADY   = '0;
        @(posedge PCLK); #1;
        checkOutput("pre_reset_penable", PENABLE, 1);
        @(negedge PCLK); #1;
        PRESET = 1'b1;
        #1;
        checkOutput("rst_psel", PSEL, 0);
        checkOutput("rst_penable", PENABLE, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_paddr", PADDR, 0);
        checkOutput("rst_pwrite", PWRITE, 0);
        checkOutput("rst_pwdata", PWDATA, 0);
        checkOutput("rst_pstrb", PSTRB, 0);
        checkOutput("rst_ready", ready, 0);
        checkOutput("rst_error", error, 0);
        checkOutput("rst_rdata", rdata, 0);
        PREADY = '1;
        @(negedge PCLK);
        PRESET = 1'b0;
        modelRdata = '0;
        repeat (3) begin
            @(posedge PCLK); #1;
            checkOutput("post_rst_ready", ready, 0);
            checkOutput("post_rst_busy", busy, 0);
        end
    endtask

    initial begin
        req_t r;
        PRESET = 1'b1;
        repeat (3) @(posedge PCLK);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_psel", PSEL, 0);
        checkOutput("reset_penable", PENABLE, 0);
        checkOutput("reset_ready", ready, 0);
        checkOutput("reset_error", error, 0);
        checkOutput("reset_rdata", rdata, 0);
        checkOutput("reset_paddr", PADDR, 0);
        @(negedge PCLK);
        PRESET = 1'b0;

        $display("[TB] directed transfers");
        reqQ.push_back(mkReq(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, 32'h0));
        applyStimulus(1'b0);
        reqQ.push_back(mkReq(1'b0, 32'h1000_3000, 32'h0, 4'hF, 3, 1'b0, 32'h1234_5678));
        applyStimulus(1'b0);
        reqQ.push_back(mkReq(1'b1, 32'h1000_0010, 32'hA5A5_0001, 4'h3, 0, 1'b0, 32'h0));
        reqQ.push_back(mkReq(1'b1, 32'h1000_2020, 32'h5A5A_0002, 4'hC, 0, 1'b0, 32'h0));
        applyStimulus(1'b1);
        reqQ.push_back(mkReq(1'b0, 32'h2000_0000, 32'h0, 4'hF, 0, 1'b0, 32'hFFFF_FFFF));
        applyStimulus(1'b0);
        reqQ.push_back(mkReq(1'b1, 32'h1000_2008, 32'h0BAD_F00D, 4'hF, 1, 1'b1, 32'h0));
        applyStimulus(1'b0);
        reqQ.push_back(mkReq(1'b0, 32'h1000_3FFC, 32'h0, 4'h0, 0, 1'b0, 32'hCAFE_0003));
        reqQ.push_back(mkReq(1'b0, 32'h1000_4000, 32'h0, 4'h0, 0, 1'b0, 32'h7777_7777));
        applyStimulus(1'b1);

        $display("[TB] reset during access");
        applyResetMidAccess();
        reqQ.push_back(mkReq(1'b0, 32'h1000_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0F0F_1234));
        applyStimulus(1'b0);

`ifdef APB_MANAGER_TIMEOUT_EN
        $display("[TB] access timeout");
        r = mkReq(1'b0, 32'h1000_3010, 32'h0, 4'h0, 0, 1'b0, 32'h1111_2222);
        r.stuck = 1'b1;
        reqQ.push_back(r);
        applyStimulus(1'b0);
`endif

        $display("[TB] random bursts");
        for (int b = 0; b < 24; b++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                r = randReq();
                reqQ.push_back(r);
            end
            applyStimulus(1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule

// File: doc/apb_manager_nch.md
APB_MANAGER_NCH -- requirements
Module: apb_manager_nch

Interface
REQ-001 SHALL have parameter NUM_SUB, default 4, number of subordinate slots (2..16).
REQ-002 SHALL have parameter DATA_W, default 32, data bus width (multiple of 8).
REQ-003 SHALL have parameter BASE_ADDR, default 32'h1000_0000, start of the decoded window.
REQ-004 SHALL have parameter SLOT_BITS, default 12, log2 of the bytes per slot (4 KiB).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 255, the ACCESS wait limit (used only with REQ-031).
REQ-006 PCLK  in  1  sole clock; all logic on rising edge.
REQ-007 PRESET  in  1  reset, asynchronous, active-high.
REQ-008 PADDR  out  32  latched address. PWRITE  out  1  latched direction.
REQ-009 PWDATA  out  DATA_W  latched write data. PSTRB  out  DATA_W/8  latched byte strobes, forced to 0 on reads.
REQ-010 PSEL  out  NUM_SUB  one-hot select. PENABLE  out  1  access phase.
REQ-011 PRDATA  in  NUM_SUB*DATA_W  packed read data, slot k at bits [k*DATA_W +: DATA_W]. PREADY  in  NUM_SUB. PSLVERR  in  NUM_SUB.
REQ-012 transfer  in  1  request valid. write  in  1. addr  in  32. wdata  in  DATA_W. strb  in  DATA_W/8.
REQ-013 rdata  out  DATA_W  registered read result. ready  out  1  one-cycle completion pulse. error  out  1  valid with ready. busy  out  1  high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, SETUP and ACCESS.
REQ-015 Request acceptance: SHALL latch write, addr, wdata and strb when transfer=1 in IDLE, or in ACCESS on the completion cycle.
REQ-016 Transitions: IDLE->SETUP on accept; SETUP->ACCESS always; ACCESS->SETUP on completion with transfer=1; ACCESS->IDLE on completion with transfer=0; otherwise hold ACCESS.
REQ-017 Decode: slot = PADDR[SLOT_BITS +: clog2(NUM_SUB)], valid only when PADDR is in [BASE_ADDR, BASE_ADDR + NUM_SUB<<SLOT_BITS).
REQ-018 PSEL[slot] SHALL be high in SETUP and ACCESS, otherwise all PSEL bits low; PENABLE SHALL be high only in ACCESS.
REQ-019 Completion SHALL occur on an ACCESS cycle where PREADY[slot]=1.
REQ-020 On completion, ready SHALL pulse on the next cycle, with error=PSLVERR[slot].
REQ-021 On read completion, rdata SHALL load PRDATA[slot]; otherwise rdata SHALL hold its value.
REQ-022 Unmapped address: no PSEL asserted, same cycle timing, ACCESS completes immediately, ready pulses with error=1 and rdata=0.
REQ-023 Minimum latency: accept at cycle N -> SETUP N+1 -> ACCESS N+2 -> ready N+3, giving 2 bus cycles per back-to-back transfer.
REQ-024 transfer sampled in SETUP or in a non-completing ACCESS cycle SHALL be ignored; no request queueing.
REQ-025 PADDR, PWRITE, PWDATA and PSTRB SHALL stay stable from SETUP through the completing ACCESS cycle.

Reset
REQ-026 PRESET=1 SHALL immediately force state=IDLE and all outputs to 0, including mid-transfer.
REQ-027 A transfer interrupted by reset SHALL NOT produce a ready pulse.
REQ-028 The first accept after reset release SHALL be on the first PCLK edge with transfer=1.

Configuration
REQ-029 Macro APB_MANAGER_TIMEOUT_EN SHALL control the ACCESS timeout counter.
REQ-030 The counter SHALL be 8 bits minimum and sized to hold TIMEOUT_CYCLES.
REQ-031 With the macro defined: if ACCESS lasts TIMEOUT_CYCLES cycles without PREADY, the transfer SHALL abort: ready with error=1 and rdata=0, next state per REQ-016.
REQ-032 Without the macro: ACCESS SHALL wait indefinitely, with no counter logic present.

Structure
REQ-033 Package apb_pkg SHALL hold the state enum apb_state_e, default BASE_ADDR/SLOT_BITS constants and TIMEOUT_CYCLES default.
REQ-034 Sub-module apb_slot_decode SHALL be combinational: inputs PADDR and en; outputs one-hot sel, binary idx and hit.
REQ-035 The read-data and PREADY mux SHALL be inline in apb_manager_nch.

Verification
REQ-036 Write addr=32'h1000_1004, wdata=32'hDEAD_BEEF, strb=4'hF, PREADY1 high -> PSEL=4'b0010, PENABLE high at N+2, ready at N+3, error=0.
REQ-037 Read 32'h1000_3000, PREADY3 low for 3 cycles, PRDATA3=32'h1234_5678 -> ACCESS held 4 cycles, rdata=32'h1234_5678, PADDR stable throughout.
REQ-038 Back-to-back writes to slots 0 and 2 with transfer held high -> PSEL 0001 then 0100, with ready pulses 2 cycles apart.
REQ-039 Read 32'h2000_0000 -> PSEL=0 throughout, ready at N+3, error=1, rdata=0; PSLVERR2=1 on a slot-2 write -> error=1.
REQ-040 PRESET asserted during ACCESS -> all outputs 0 asynchronously, no ready pulse; with APB_MANAGER_TIMEOUT_EN and TIMEOUT_CYCLES=4, PREADY stuck low -> error=1 after 4 ACCESS cycles.
